// File: rtl/dram_lsu_if.sv
// Request/response bundle for the dram_lsu word-array load/store unit.
// The master side issues byte/half/word requests; the slave returns one response per accepted request.
interface dram_lsu_if #(
  parameter int ADDR_W = 18
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dram_lsu.sv
// Load/store unit over a 32-bit word array with byte-lane stores, sign/zero-extended loads,
// optional zero-fill after reset, and a fixed-latency (1 or 2 cycle) in-order response pipe.
module dram_lsu #(
  parameter int ADDR_W         = 18,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dram_lsu_if.slave   bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // size 11 is illegal; half needs addr[0]=0, word needs addr[1:0]=00
  function automatic logic f_size_err(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = lo[0];
      2'b10:   err = (lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] f_lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001 << lo;
      2'b01:   mask = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Replicate right-aligned store data onto every lane so the mask alone picks the target
  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] data;
    case (size)
      2'b00:   data = {4{wd[7:0]}};
      2'b01:   data = {2{wd[15:0]}};
      default: data = wd;
    endcase
    return data;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lo,
                                         input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] data;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   data = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   data = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   data = word;
      default: data = 32'h0000_0000;
    endcase
    return data;
  endfunction

  logic [31:0]      r_mem [DEPTH];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_clr_cnt;
  logic             r_v1;
  logic [31:0]      r_d1;
  logic             r_e1;

  logic             w_ready;
  logic             w_acc;
  logic             w_err;
  logic             w_st_we;
  logic             w_clr_we;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lo;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rsp_data;

  assign w_ready       = rst_n && (r_state == ST_RUN);
  assign w_clr_we      = rst_n && (r_state == ST_INIT) && (CLEAR_ON_RESET != 0);
  assign bus.req_ready = w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (CLEAR_ON_RESET == 0) begin
          w_state_nxt = ST_RUN;
        end else if (r_clr_cnt == {IDX_W{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if (w_clr_we) begin
      r_clr_cnt <= r_clr_cnt + IDX_W'(1);
    end else begin
      r_clr_cnt <= r_clr_cnt;
    end
  end

  always_comb begin
    w_idx   = bus.req_addr[ADDR_W-1:2];
    w_lo    = bus.req_addr[1:0];
    w_err   = f_size_err(bus.req_size, w_lo);
    w_acc   = bus.req_valid && w_ready;
    w_st_we = w_acc && bus.req_we && !w_err;
    w_be    = f_lane_mask(bus.req_size, w_lo);
    w_wdata = f_wdata(bus.req_size, bus.req_wdata);
    if (w_acc && !bus.req_we && !w_err) begin
      w_rsp_data = f_load(r_mem[w_idx], w_lo, bus.req_size, bus.req_unsigned);
    end else begin
      w_rsp_data = 32'h0000_0000;
    end
  end

  // Array has no reset; contents survive reset unless the INIT sweep zeroes them
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= 32'h0000_0000;
    end else if (w_st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_d1 <= 32'h0000_0000;
      r_e1 <= 1'b0;
    end else begin
      r_v1 <= w_acc;
      r_d1 <= w_rsp_data;
      r_e1 <= w_acc && w_err;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic        r_v2;
      logic [31:0] r_d2;
      logic        r_e2;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_d2 <= 32'h0000_0000;
          r_e2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          r_d2 <= r_d1;
          r_e2 <= r_e1;
        end
      end

      assign bus.rsp_valid = r_v2;
      assign bus.rsp_rdata = r_d2;
      assign bus.rsp_err   = r_e2;
    end else begin : g_lat1
      assign bus.rsp_valid = r_v1;
      assign bus.rsp_rdata = r_d1;
      assign bus.rsp_err   = r_e1;
    end
  endgenerate

endmodule

// File: tb/tb_dram_lsu.sv
// Directed bench: three dram_lsu instances (lat1+clear, lat2+clear, lat1+keep) with ADDR_W=6.
module tb_dram_lsu;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  t_valid;
  logic [2:0]  t_we;
  logic [2:0]  t_uns;
  logic [5:0]  t_addr  [3];
  logic [1:0]  t_size  [3];
  logic [31:0] t_wdata [3];
  logic [2:0]  o_ready;
  logic [2:0]  o_valid;
  logic [2:0]  o_err;
  logic [31:0] o_rdata [3];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  dram_lsu_if #(.ADDR_W(6)) if_a ();
  dram_lsu_if #(.ADDR_W(6)) if_b ();
  dram_lsu_if #(.ADDR_W(6)) if_c ();

  dram_lsu #(.ADDR_W(6), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_a (.clk(clk), .rst_n(rst[0]), .bus(if_a));
  dram_lsu #(.ADDR_W(6), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_b (.clk(clk), .rst_n(rst[1]), .bus(if_b));
  dram_lsu #(.ADDR_W(6), .RD_LAT(1), .CLEAR_ON_RESET(0)) u_c (.clk(clk), .rst_n(rst[2]), .bus(if_c));

  assign if_a.req_valid = t_valid[0];  assign if_b.req_valid = t_valid[1];  assign if_c.req_valid = t_valid[2];
  assign if_a.req_we    = t_we[0];     assign if_b.req_we    = t_we[1];     assign if_c.req_we    = t_we[2];
  assign if_a.req_unsigned = t_uns[0]; assign if_b.req_unsigned = t_uns[1]; assign if_c.req_unsigned = t_uns[2];
  assign if_a.req_addr  = t_addr[0];   assign if_b.req_addr  = t_addr[1];   assign if_c.req_addr  = t_addr[2];
  assign if_a.req_size  = t_size[0];   assign if_b.req_size  = t_size[1];   assign if_c.req_size  = t_size[2];
  assign if_a.req_wdata = t_wdata[0];  assign if_b.req_wdata = t_wdata[1];  assign if_c.req_wdata = t_wdata[2];
  assign o_ready = {if_c.req_ready, if_b.req_ready, if_a.req_ready};
  assign o_valid = {if_c.rsp_valid, if_b.rsp_valid, if_a.rsp_valid};
  assign o_err   = {if_c.rsp_err,   if_b.rsp_err,   if_a.rsp_err};
  assign o_rdata[0] = if_a.rsp_rdata;
  assign o_rdata[1] = if_b.rsp_rdata;
  assign o_rdata[2] = if_c.rsp_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on instance d; returns the response sampled at its expected latency
  task automatic do_req(input int d, input logic we, input logic [5:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output logic v, output logic [31:0] rd, output logic er);
    t_valid[d] = 1'b1; t_we[d] = we; t_addr[d] = addr; t_size[d] = size; t_uns[d] = uns; t_wdata[d] = wd;
    tick();
    t_valid[d] = 1'b0;
    if (d == 1) tick();
    v = o_valid[d]; rd = o_rdata[d]; er = o_err[d];
  endtask

  task automatic wait_ready(input int d, output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (o_ready[d]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int first [3];
    rst = 3'b000;
    t_valid = 3'b000; t_we = 3'b000; t_uns = 3'b000;
    for (int d = 0; d < 3; d++) begin
      t_addr[d] = 6'h00; t_size[d] = 2'b10; t_wdata[d] = 32'h0; first[d] = 0;
    end
    repeat (3) tick();
    checks++;
    if ({o_ready, o_valid, o_err} !== 9'b0 || o_rdata[0] !== 32'h0 || o_rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b, want all 0", o_ready, o_valid, o_err);
    end
    rst = 3'b111;
    for (int k = 1; k <= 40; k++) begin
      tick();
      for (int d = 0; d < 3; d++) if (first[d] == 0 && o_ready[d]) first[d] = k;
    end
    checks++;
    if (first[0] != 16 || first[1] != 16 || first[2] != 1) begin
      errors++;
      $display("FAIL ready_delay: got a=%0d b=%0d c=%0d, want 16 16 1", first[0], first[1], first[2]);
    end
  endtask

  task automatic test_clear();
    logic v, er;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) begin
      do_req(0, 1'b0, 6'(i * 4), 2'b10, 1'b0, 32'h0, v, rd, er);
      checks++;
      if ({v, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL clear_word%0d: got v=%b err=%b data=%h, want v=1 err=0 data=00000000", i, v, er, rd);
      end
    end
  endtask

  task automatic test_store_load();
    vec_t tbl [23];
    logic v, er;
    logic [31:0] rd;
    tbl[0]  = '{1'b1, 6'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 6'h13, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[2]  = '{1'b0, 6'h10, 2'b01, 1'b1, 32'h0,        32'h0000BEEF, 1'b0};
    tbl[3]  = '{1'b0, 6'h12, 2'b01, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[4]  = '{1'b0, 6'h10, 2'b00, 1'b1, 32'h0,        32'h000000EF, 1'b0};
    tbl[5]  = '{1'b1, 6'h11, 2'b00, 1'b0, 32'hAAAAAA55, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b0, 6'h10, 2'b10, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0};
    tbl[7]  = '{1'b1, 6'h12, 2'b01, 1'b0, 32'hFFFF1234, 32'h00000000, 1'b0};
    tbl[8]  = '{1'b0, 6'h10, 2'b10, 1'b1, 32'h0,        32'h123455EF, 1'b0};
    tbl[9]  = '{1'b0, 6'h12, 2'b00, 1'b0, 32'h0,        32'h00000034, 1'b0};
    tbl[10] = '{1'b0, 6'h13, 2'b00, 1'b0, 32'h0,        32'h00000012, 1'b0};
    tbl[11] = '{1'b1, 6'h12, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[12] = '{1'b1, 6'h13, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[13] = '{1'b1, 6'h10, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[14] = '{1'b0, 6'h10, 2'b10, 1'b0, 32'h0,        32'h123455EF, 1'b0};
    tbl[15] = '{1'b0, 6'h10, 2'b11, 1'b0, 32'h0,        32'h00000000, 1'b1};
    tbl[16] = '{1'b0, 6'h11, 2'b01, 1'b0, 32'h0,        32'h00000000, 1'b1};
    tbl[17] = '{1'b0, 6'h11, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1};
    tbl[18] = '{1'b1, 6'h3C, 2'b10, 1'b0, 32'h80008001, 32'h00000000, 1'b0};
    tbl[19] = '{1'b0, 6'h3F, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[20] = '{1'b0, 6'h3C, 2'b01, 1'b0, 32'h0,        32'hFFFF8001, 1'b0};
    tbl[21] = '{1'b0, 6'h3E, 2'b01, 1'b1, 32'h0,        32'h00008000, 1'b0};
    tbl[22] = '{1'b0, 6'h3C, 2'b00, 1'b1, 32'h0,        32'h00000001, 1'b0};
    for (int i = 0; i < 23; i++) begin
      do_req(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wd, v, rd, er);
      checks++;
      if ({v, er, rd} !== {1'b1, tbl[i].err, tbl[i].rd}) begin
        errors++;
        $display("FAIL vec%0d: got v=%b err=%b data=%h, want v=1 err=%b data=%h",
                 i, v, er, rd, tbl[i].err, tbl[i].rd);
      end
    end
    tick();
    checks++;
    if ({o_valid[0], o_err[0], o_rdata[0]} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL idle_rsp: got v=%b err=%b data=%h, want all 0", o_valid[0], o_err[0], o_rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic v, er;
    logic [31:0] rd;
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'hC0DE_0000 + 32'(i * 17);
      do_req(1, 1'b1, 6'(i * 4), 2'b10, 1'b0, vals[i], v, rd, er);
    end
    t_we[1] = 1'b0; t_size[1] = 2'b10; t_uns[1] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      t_valid[1] = (j < 4);
      t_addr[1]  = 6'((j % 4) * 4);
      tick();
      checks++;
      if (j >= 1 && j <= 4) begin
        if ({o_valid[1], o_err[1], o_rdata[1]} !== {1'b1, 1'b0, vals[j-1]}) begin
          errors++;
          $display("FAIL b2b_slot%0d: got v=%b data=%h, want v=1 data=%h", j, o_valid[1], o_rdata[1], vals[j-1]);
        end
      end else if ({o_valid[1], o_rdata[1]} !== {1'b0, 32'h0}) begin
        errors++;
        $display("FAIL b2b_slot%0d: got v=%b data=%h, want v=0 data=0", j, o_valid[1], o_rdata[1]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int pulses;
    int n;
    t_valid[1] = 1'b1; t_we[1] = 1'b0; t_size[1] = 2'b10; t_addr[1] = 6'h00;
    tick();
    t_addr[1] = 6'h04;
    tick();
    t_valid[1] = 1'b0;
    checks++;
    if (o_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL inflight_first: got v=%b, want 1", o_valid[1]);
    end
    rst[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    pulses = 0;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (o_valid[1]) pulses++;
      if (n == 0 && o_ready[1]) n = k;
    end
    checks++;
    if (pulses != 0 || n != 16) begin
      errors++;
      $display("FAIL inflight_drop: got pulses=%0d ready_at=%0d, want 0 and 16", pulses, n);
    end
  endtask

  task automatic test_mid_init_reset();
    int n;
    logic v, er;
    logic [31:0] rd;
    rst[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    repeat (5) tick();
    rst[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    wait_ready(0, n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL init_restart: got ready after %0d cycles, want 16", n);
    end
    do_req(0, 1'b0, 6'h3C, 2'b10, 1'b0, 32'h0, v, rd, er);
    checks++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reclear: got v=%b err=%b data=%h, want v=1 err=0 data=00000000", v, er, rd);
    end
  endtask

  task automatic test_keep();
    int n;
    logic v, er;
    logic [31:0] rd;
    do_req(2, 1'b1, 6'h20, 2'b10, 1'b0, 32'h12345678, v, rd, er);
    rst[2] = 1'b0;
    repeat (2) tick();
    rst[2] = 1'b1;
    wait_ready(2, n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL keep_ready: got ready after %0d cycles, want 1", n);
    end
    do_req(2, 1'b0, 6'h20, 2'b10, 1'b0, 32'h0, v, rd, er);
    checks++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'h12345678}) begin
      errors++;
      $display("FAIL keep_word: got v=%b err=%b data=%h, want v=1 err=0 data=12345678", v, er, rd);
    end
    do_req(2, 1'b0, 6'h21, 2'b00, 1'b0, 32'h0, v, rd, er);
    checks++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'h00000056}) begin
      errors++;
      $display("FAIL keep_byte: got v=%b err=%b data=%h, want v=1 err=0 data=00000056", v, er, rd);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_store_load();
    test_back_to_back();
    test_reset_inflight();
    test_mid_init_reset();
    test_keep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_lsu.md
DRAM_LSU -- requirements
Module: dram_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, byte-address width; depth = 2**(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter RD_LAT, default 1, request-to-response latency in cycles; legal values 1 or 2.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero entire array after reset, 0 = keep contents.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-012 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 SHALL have port rsp_valid  output  1  response present, one-cycle pulse per accepted request.
REQ-014 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  request was misaligned or illegal size.

Function
REQ-016 SHALL implement FSM states INIT and RUN; req_ready = 1 only in RUN.
REQ-017 SHALL, in INIT with CLEAR_ON_RESET=1, write 0 to one word per cycle, word index counter 0..depth-1, entering RUN on the cycle after the last word is written (INIT lasts exactly depth cycles).
REQ-018 SHALL, with CLEAR_ON_RESET=0, enter RUN on the first cycle after rst_n is sampled high (INIT lasts 1 cycle).
REQ-019 SHALL accept a request on any cycle with req_valid && req_ready; accepts back-to-back every cycle, no response backpressure.
REQ-020 SHALL flag error when req_size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00; an errored request SHALL not modify memory.
REQ-021 SHALL, for a legal store, write only the addressed byte lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all 4 lanes; other lanes unchanged.
REQ-022 SHALL commit a store on the accept edge, so a load accepted the next cycle at an overlapping address returns the new data.
REQ-023 SHALL, for a legal load, select the addressed byte/half/word and extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-024 SHALL assert rsp_valid exactly RD_LAT cycles after the accept edge, with rsp_rdata/rsp_err belonging to that request; responses in request order.
REQ-025 SHALL hold rsp_rdata = 0 and rsp_err = 0 whenever rsp_valid = 0.
REQ-026 SHALL issue a response for stores (rdata 0, err per REQ-020) and for errored loads (rdata 0, err 1).
REQ-027 SHALL use word index req_addr[ADDR_W-1:2]; no wrap or range check beyond ADDR_W.

Reset
REQ-028 SHALL, on any cycle rst_n=0: enter INIT, clear clear-counter to 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 SHALL discard in-flight responses on reset; no response for them is ever produced.
REQ-030 SHALL, on reset mid-INIT, restart clearing from word 0.
REQ-031 SHALL preserve array contents across reset when CLEAR_ON_RESET=0.

Verification
REQ-032 ADDR_W=6, CLEAR_ON_RESET=1: release reset -> req_ready rises after exactly 16 cycles; word load of every address returns 0x00000000.
REQ-033 RD_LAT=1: store word 0xDEADBEEF @0x10, next cycle load byte @0x13 signed -> rsp 0xFFFFFFDE; load half @0x10 unsigned -> 0x0000BEEF.
REQ-034 Store byte 0x55 @0x11 over 0xDEADBEEF -> word load @0x10 returns 0xDEAD55EF.
REQ-035 Word store @0x12 -> rsp_err=1, rsp_rdata=0; subsequent word load @0x10 unchanged; req_size=11 load -> rsp_err=1.
REQ-036 RD_LAT=2: 4 back-to-back loads -> 4 rsp_valid pulses on cycles accept+2, in order; reset asserted with 2 in flight -> zero further responses.
REQ-037 CLEAR_ON_RESET=0: store 0x12345678 @0x20, reset, load @0x20 -> 0x12345678; req_ready high 1 cycle after rst_n high.
